// File: rtl/systolic_feeder.sv
// West/north edge feeder for a square systolic MAC array: per-lane diagonal skew
// of accepted A/B slices plus the clear/feed/drain/done tile sequencer.
module systolic_feeder #(
   parameter int word_size = 16,
   parameter int array_dim = 4,
   parameter int k_depth   = 8
) (
   input  logic                           clk,
   input  logic                           clear,
   input  logic                           start,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [0:array_dim*word_size-1] a_in,
   input  logic [0:array_dim*word_size-1] b_in,
   output logic [0:array_dim*word_size-1] a_skew,
   output logic [0:array_dim*word_size-1] b_skew,
   output logic                           mac_clear,
   output logic                           busy,
   output logic                           done
);

   localparam int cnt_w = (k_depth > 1) ? $clog2(k_depth) : 1;
   localparam int drn_w = $clog2(2 * array_dim);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] CLR   = 3'd1;
   localparam logic [2:0] FEED  = 3'd2;
   localparam logic [2:0] DRAIN = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;

   logic [2:0]       state_r;
   logic [2:0]       next_s;
   logic [cnt_w-1:0] slice_cnt_r;
   logic [drn_w-1:0] drain_cnt_r;
   logic             accept_s;
   logic             last_slice_s;
   logic             drain_end_s;
   logic             in_ready_r;
   logic             mac_clear_r;
   logic             busy_r;
   logic             done_r;

   assign accept_s     = (state_r == FEED) && in_valid;
   assign last_slice_s = (slice_cnt_r == cnt_w'(k_depth - 1));
   assign drain_end_s  = (drain_cnt_r == drn_w'(2 * array_dim - 1));

   // Tile sequencer next-state decode
   always_comb begin
      next_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) next_s = CLR;
            else       next_s = IDLE;
         end
         CLR:  next_s = FEED;
         FEED: begin
            if (accept_s && last_slice_s) next_s = DRAIN;
            else                          next_s = FEED;
         end
         DRAIN: begin
            if (drain_end_s) next_s = DONE;
            else             next_s = DRAIN;
         end
         DONE:    next_s = IDLE;
         default: next_s = IDLE;
      endcase
   end

   // State, counters and registered status outputs (decoded from next state)
   always_ff @(posedge clk) begin
      if (clear) begin
         state_r     <= IDLE;
         slice_cnt_r <= {cnt_w{1'b0}};
         drain_cnt_r <= {drn_w{1'b0}};
         in_ready_r  <= 1'b0;
         mac_clear_r <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         state_r     <= next_s;
         in_ready_r  <= (next_s == FEED);
         mac_clear_r <= (next_s == CLR);
         busy_r      <= (next_s != IDLE);
         done_r      <= (next_s == DONE);
         if (state_r != FEED)  slice_cnt_r <= {cnt_w{1'b0}};
         else if (!accept_s)   slice_cnt_r <= slice_cnt_r;
         else if (last_slice_s) slice_cnt_r <= {cnt_w{1'b0}};
         else                  slice_cnt_r <= slice_cnt_r + cnt_w'(1);
         if (state_r == DRAIN) drain_cnt_r <= drain_cnt_r + drn_w'(1);
         else                  drain_cnt_r <= {drn_w{1'b0}};
      end
   end

   assign in_ready  = in_ready_r;
   assign mac_clear = mac_clear_r;
   assign busy      = busy_r;
   assign done      = done_r;

   // Lane i: entry register plus i delay stages; bubbles and non-FEED cycles load zero
   for (genvar i = 0; i < array_dim; i++) begin : g_lane
      logic [word_size-1:0] a_pipe_r [0:i];
      logic [word_size-1:0] b_pipe_r [0:i];

      // Skew shift registers for this lane
      always_ff @(posedge clk) begin
         if (clear) begin
            for (int s = 0; s <= i; s++) begin
               a_pipe_r[s] <= {word_size{1'b0}};
               b_pipe_r[s] <= {word_size{1'b0}};
            end
         end else begin
            a_pipe_r[0] <= accept_s ? a_in[i*word_size +: word_size] : {word_size{1'b0}};
            b_pipe_r[0] <= accept_s ? b_in[i*word_size +: word_size] : {word_size{1'b0}};
            for (int s = 1; s <= i; s++) begin
               a_pipe_r[s] <= a_pipe_r[s-1];
               b_pipe_r[s] <= b_pipe_r[s-1];
            end
         end
      end

      assign a_skew[i*word_size +: word_size] = a_pipe_r[i];
      assign b_skew[i*word_size +: word_size] = b_pipe_r[i];
   end

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: a 4-lane instance for skew timing and a 2x2 instance
// driving a behavioural MAC array, checked against a cycle-history model and matrix products.
module tb_systolic_feeder;
   localparam int WS = 16;
   localparam int N2 = 2;
   localparam int K2 = 2;
   localparam int N4 = 4;
   localparam int K4 = 1;

   typedef logic [0:N2*WS-1] vec2_t;
   typedef logic [0:N4*WS-1] vec4_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic  clear, start2, valid2, rdy2, mc2, busy2, done2;
   logic  start4, valid4, rdy4, mc4, busy4, done4;
   vec2_t a2, b2, as2, bs2;
   vec4_t a4, b4, as4, bs4;

   systolic_feeder #(.word_size(WS), .array_dim(N2), .k_depth(K2)) u_dut2 (
      .clk(clk), .clear(clear), .start(start2), .in_valid(valid2), .in_ready(rdy2),
      .a_in(a2), .b_in(b2), .a_skew(as2), .b_skew(bs2),
      .mac_clear(mc2), .busy(busy2), .done(done2));

   systolic_feeder #(.word_size(WS), .array_dim(N4), .k_depth(K4)) u_dut4 (
      .clk(clk), .clear(clear), .start(start4), .in_valid(valid4), .in_ready(rdy4),
      .a_in(a4), .b_in(b4), .a_skew(as4), .b_skew(bs4),
      .mac_clear(mc4), .busy(busy4), .done(done4));

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int flush_cyc = -1;

   logic [WS-1:0] hist_a [0:8191][0:N2-1];
   logic [WS-1:0] hist_b [0:8191][0:N2-1];
   int mat_a [N2][K2];
   int mat_b [K2][N2];

   // Behavioural 2x2 output-stationary MAC array fed by the 2-lane instance
   int pe_a   [N2][N2];
   int pe_b   [N2][N2];
   int pe_acc [N2][N2];

   function automatic int west(int i, int j);
      if (j == 0) return int'(as2[i*WS +: WS]);
      return pe_a[i][j-1];
   endfunction

   function automatic int north(int i, int j);
      if (i == 0) return int'(bs2[j*WS +: WS]);
      return pe_b[i-1][j];
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < N2; i++) begin
         for (int j = 0; j < N2; j++) begin
            pe_a[i][j]   <= west(i, j);
            pe_b[i][j]   <= north(i, j);
            pe_acc[i][j] <= mc2 ? 0 : pe_acc[i][j] + west(i, j) * north(i, j);
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   function automatic vec2_t rnd2();
      vec2_t v;
      for (int i = 0; i < N2; i++) v[i*WS +: WS] = WS'($urandom);
      return v;
   endfunction

   // One cycle of the 2-lane instance: drive, check flags and skew against history, record acceptance
   task automatic step2(input logic clr, input logic st, input logic vld, input vec2_t a, input vec2_t b,
                        input logic e_rdy, input logic e_mc, input logic e_busy, input logic e_done);
      clear = clr; start2 = st; valid2 = vld; a2 = a; b2 = b;
      @(negedge clk);
      chk("in_ready", rdy2, e_rdy);
      chk("mac_clear", mc2, e_mc);
      chk("busy", busy2, e_busy);
      chk("done", done2, e_done);
      for (int i = 0; i < N2; i++) begin
         int src;
         logic [WS-1:0] ea, eb;
         src = cyc - 1 - i;
         ea = (src >= 0 && src > flush_cyc) ? hist_a[src][i] : '0;
         eb = (src >= 0 && src > flush_cyc) ? hist_b[src][i] : '0;
         chk($sformatf("a_skew[%0d]", i), as2[i*WS +: WS], ea);
         chk($sformatf("b_skew[%0d]", i), bs2[i*WS +: WS], eb);
         hist_a[cyc][i] = (e_rdy && vld && !clr) ? a[i*WS +: WS] : '0;
         hist_b[cyc][i] = (e_rdy && vld && !clr) ? b[i*WS +: WS] : '0;
      end
      if (clr) flush_cyc = cyc;
      tick();
   endtask

   task automatic chk_results();
      for (int i = 0; i < N2; i++) begin
         for (int j = 0; j < N2; j++) begin
            int sum;
            sum = 0;
            for (int k = 0; k < K2; k++) sum += mat_a[i][k] * mat_b[k][j];
            chk($sformatf("pe_acc[%0d][%0d]", i, j), pe_acc[i][j], sum);
         end
      end
   endtask

   // Whole tile on the 2-lane instance; mode 0 dense, 1 alternate bubbles, 2 random bubbles
   task automatic run_tile2(input int mode, input logic hold, input int abort_at);
      vec2_t va, vb;
      int k, fc;
      logic v;
      step2(1'b0, 1'b1, 1'($urandom_range(0, 1)), rnd2(), rnd2(), 1'b0, 1'b0, 1'b0, 1'b0);
      step2(1'b0, hold, 1'($urandom_range(0, 1)), rnd2(), rnd2(), 1'b0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < N2; i++)
         for (int j = 0; j < N2; j++) chk("acc_cleared", pe_acc[i][j], 0);
      k = 0;
      fc = 0;
      while (k < K2) begin
         case (mode)
            0:       v = 1'b1;
            1:       v = (fc % 2 == 1);
            default: v = (fc > 20) ? 1'b1 : 1'($urandom_range(0, 1));
         endcase
         va = rnd2();
         vb = rnd2();
         if (v) begin
            for (int i = 0; i < N2; i++) begin
               va[i*WS +: WS] = WS'(mat_a[i][k]);
               vb[i*WS +: WS] = WS'(mat_b[k][i]);
            end
         end
         step2(1'b0, hold, v, va, vb, 1'b1, 1'b0, 1'b1, 1'b0);
         if (v) k++;
         fc++;
      end
      for (int d = 0; d < 2 * N2; d++) begin
         if (d == abort_at) begin
            step2(1'b1, hold, 1'($urandom_range(0, 1)), rnd2(), rnd2(), 1'b0, 1'b0, 1'b1, 1'b0);
            return;
         end
         step2(1'b0, hold, 1'($urandom_range(0, 1)), rnd2(), rnd2(), 1'b0, 1'b0, 1'b1, 1'b0);
      end
      step2(1'b0, hold, 1'($urandom_range(0, 1)), rnd2(), rnd2(), 1'b0, 1'b0, 1'b1, 1'b1);
      chk_results();
   endtask

   task automatic set_example();
      mat_a[0][0] = 1; mat_a[0][1] = 2; mat_a[1][0] = 3; mat_a[1][1] = 4;
      mat_b[0][0] = 5; mat_b[0][1] = 6; mat_b[1][0] = 7; mat_b[1][1] = 8;
   endtask

   task automatic set_random();
      for (int i = 0; i < N2; i++)
         for (int k = 0; k < K2; k++) begin
            mat_a[i][k] = $urandom_range(0, 255);
            mat_b[k][i] = $urandom_range(0, 255);
         end
   endtask

   initial begin
      int t_acc;
      clear = 1'b1; start2 = 1'b0; valid2 = 1'b0; a2 = '0; b2 = '0;
      start4 = 1'b0; valid4 = 1'b0; a4 = '0; b4 = '0;
      tick();
      tick();
      flush_cyc = cyc - 1;

      // Idle after reset, garbage on the inputs must not be taken
      for (int c = 0; c < 5; c++) begin
         valid4 = 1'b1;
         a4 = {N4{16'hBEEF}};
         b4 = {N4{16'hCAFE}};
         step2(1'b0, 1'b0, 1'b1, rnd2(), rnd2(), 1'b0, 1'b0, 1'b0, 1'b0);
         chk("idle4_ready", rdy4, 1'b0);
         chk("idle4_busy", busy4, 1'b0);
         chk("idle4_mc", mc4, 1'b0);
         chk("idle4_done", done4, 1'b0);
         chk("idle4_a_skew", as4, '0);
         chk("idle4_b_skew", bs4, '0);
      end

      // Skew timing on the 4-lane instance with a single slice
      valid4 = 1'b0;
      start4 = 1'b1;
      @(negedge clk);
      chk("sk_busy_idle", busy4, 1'b0);
      tick();
      start4 = 1'b0;
      @(negedge clk);
      chk("sk_mac_clear", mc4, 1'b1);
      chk("sk_ready_clr", rdy4, 1'b0);
      tick();
      valid4 = 1'b1;
      for (int i = 0; i < N4; i++) begin
         a4[i*WS +: WS] = WS'(i + 1);
         b4[i*WS +: WS] = WS'(i + 5);
      end
      @(negedge clk);
      chk("sk_ready_feed", rdy4, 1'b1);
      chk("sk_mc_feed", mc4, 1'b0);
      chk("sk_a_feed", as4, '0);
      t_acc = cyc;
      tick();
      valid4 = 1'b1;
      a4 = {N4{16'h1234}};
      b4 = {N4{16'h5678}};
      for (int c = 0; c < 2 * N4 + 1; c++) begin
         @(negedge clk);
         for (int i = 0; i < N4; i++) begin
            chk($sformatf("sk_a[%0d]", i), as4[i*WS +: WS], (cyc == t_acc + 1 + i) ? WS'(i + 1) : '0);
            chk($sformatf("sk_b[%0d]", i), bs4[i*WS +: WS], (cyc == t_acc + 1 + i) ? WS'(i + 5) : '0);
         end
         chk("sk_ready_drain", rdy4, 1'b0);
         chk("sk_busy", busy4, 1'b1);
         chk("sk_done", done4, (cyc == t_acc + 2 * N4 + 1));
         tick();
      end
      valid4 = 1'b0;
      @(negedge clk);
      chk("sk_busy_after", busy4, 1'b0);
      chk("sk_done_after", done4, 1'b0);
      tick();

      // Example tile, dense then with alternate bubbles
      set_example();
      run_tile2(0, 1'b0, -1);
      step2(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_tile2(1, 1'b0, -1);
      step2(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Abort during drain: back to idle, zero skew, no done; clear beats start
      set_random();
      run_tile2(0, 1'b0, 1);
      for (int c = 0; c < 2 * N2 + 2; c++)
         step2(1'b0, 1'b0, 1'b0, rnd2(), rnd2(), 1'b0, 1'b0, 1'b0, 1'b0);
      step2(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      step2(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      set_example();
      run_tile2(2, 1'b0, -1);

      // Start held high, back-to-back random tiles
      for (int t = 0; t < 6; t++) begin
         set_random();
         run_tile2(2, (t != 5), -1);
      end
      step2(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      step2(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
